// File: rtl/led_bank_pkg.sv
// Shared types and register map for the LED driver bank.
package led_bank_pkg;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_PWM   = 3'd3,
        MODE_PULSE = 3'd4
    } led_mode_t;

    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blinker_bank_if.sv
// Single-cycle configuration write port of the LED driver bank.
interface led_blinker_bank_if
    import led_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    localparam int CH_W = ch_width(NCH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_reg;
    logic [CNT_W-1:0] cfg_data;

    modport master (output cfg_we, cfg_ch, cfg_reg, cfg_data);
    modport slave  (input  cfg_we, cfg_ch, cfg_reg, cfg_data);

endinterface

// File: rtl/led_blinker_bank_channel.sv
// One LED channel: mode/period/duty registers, tick counter, trigger edge
// detection and the registered LED output.
module led_channel
    import led_bank_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PERIOD_RST = 500,
    parameter int MODE_RST   = 2
) (
    input  logic             pixel_clk,
    input  logic             sys_rst,
    input  logic             srst,
    input  logic             tick,
    input  logic             we_mode,
    input  logic             we_period,
    input  logic             we_duty,
    input  logic [CNT_W-1:0] wdata,
    input  logic             trig,
    output logic             led
);
    localparam logic [CNT_W-1:0] P_RST = CNT_W'(PERIOD_RST);
    localparam logic [CNT_W-1:0] D_RST = CNT_W'(PERIOD_RST / 2);
    localparam led_mode_t        M_RST = led_mode_t'(3'(MODE_RST));

    led_mode_t        mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             trig_q, trig_d;

    logic [CNT_W-1:0] last_cnt;
    logic             at_last;
    logic             rise;

    always_comb begin
        // A period of 0 runs as 1, so the terminal count is 0 in both cases.
        last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);
        at_last  = (cnt_q >= last_cnt);
        rise     = trig & ~trig_q;

        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        trig_d   = trig;

        if (srst) begin
            mode_d   = M_RST;
            period_d = P_RST;
            duty_d   = D_RST;
            cnt_d    = '0;
            led_d    = 1'b0;
            trig_d   = 1'b0;
        end else begin
            if (we_duty) duty_d = wdata;
            if (we_mode || we_period) begin
                if (we_mode)   mode_d   = led_mode_t'(wdata[2:0]);
                if (we_period) period_d = wdata;
                cnt_d = '0;
                led_d = 1'b0;
            end else begin
                case (mode_q)
                    MODE_ON: led_d = 1'b1;
                    MODE_BLINK: begin
                        if (tick) begin
                            if (at_last) begin
                                cnt_d = '0;
                                led_d = ~led_q;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    MODE_PWM: begin
                        if (tick) cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
                        led_d = (cnt_d < duty_q);
                    end
                    MODE_PULSE: begin
                        if (rise) begin
                            cnt_d = '0;
                            led_d = 1'b1;
                        end else if (led_q && tick) begin
                            if (at_last) begin
                                cnt_d = '0;
                                led_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: led_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q   <= M_RST;
            period_q <= P_RST;
            duty_q   <= D_RST;
            cnt_q    <= '0;
            led_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            trig_q   <= trig_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_blinker_bank.sv
// LED driver bank: reset synchroniser, shared prescaler and config decode
// around NCH independent led_channel instances.
module led_blinker_bank
    import led_bank_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int PRESCALE   = 31999,
    parameter int PERIOD_RST = 500,
    parameter int MODE_RST   = 2
) (
    input  logic                pixel_clk,
    input  logic                sys_rst,
    output logic                rst_o,
    led_blinker_bank_if.slave   cfg,
    input  logic [NCH-1:0]      trig_i,
    output logic [NCH-1:0]      led_o
);
    localparam int CH_W = ch_width(NCH);
    localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [1:0]      sync_q, sync_d;
    logic [PS_W-1:0] pre_q, pre_d;
    logic            tick;
    logic            we_ok;

    always_comb begin
        sync_d = {sync_q[0], 1'b0};
        tick   = ~rst_o && (pre_q == PS_W'(PRESCALE));
        pre_d  = (rst_o || tick) ? '0 : pre_q + PS_W'(1);
        we_ok  = cfg.cfg_we && ~rst_o && (int'(cfg.cfg_ch) < NCH);
    end

    // Asserts with sys_rst, releases two pixel_clk edges later.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) sync_q <= 2'b11;
        else         sync_q <= sync_d;
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) pre_q <= '0;
        else         pre_q <= pre_d;
    end

    assign rst_o = sync_q[1];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = we_ok && (cfg.cfg_ch == CH_W'(i));

        led_channel #(
            .CNT_W      (CNT_W),
            .PERIOD_RST (PERIOD_RST),
            .MODE_RST   (MODE_RST)
        ) u_ch (
            .pixel_clk (pixel_clk),
            .sys_rst   (sys_rst),
            .srst      (rst_o),
            .tick      (tick),
            .we_mode   (sel && (cfg.cfg_reg == REG_MODE)),
            .we_period (sel && (cfg.cfg_reg == REG_PERIOD)),
            .we_duty   (sel && (cfg.cfg_reg == REG_DUTY)),
            .wdata     (cfg.cfg_data),
            .trig      (trig_i[i]),
            .led       (led_o[i])
        );
    end

endmodule

// File: tb/tb_led_blinker_bank.sv
// Directed bench for led_blinker_bank with NCH=4, CNT_W=8, PRESCALE=3.
module tb_led_blinker_bank;
    import led_bank_pkg::*;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic           pixel_clk = 1'b0;
    logic           sys_rst;
    logic           rst_o;
    logic [NCH-1:0] trig_i;
    logic [NCH-1:0] led_o;

    int n_assert = 0;
    int n_fail   = 0;

    led_blinker_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg_if ();

    led_blinker_bank #(
        .NCH(NCH), .CNT_W(CNT_W), .PRESCALE(3), .PERIOD_RST(500), .MODE_RST(2)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .rst_o     (rst_o),
        .cfg       (cfg_if),
        .trig_i    (trig_i),
        .led_o     (led_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] rsel, input int data);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = 2'(ch);
        cfg_if.cfg_reg  = rsel;
        cfg_if.cfg_data = 8'(data);
        @(negedge pixel_clk);
        cfg_if.cfg_we   = 1'b0;
    endtask

    // Skips to the next change of led_o[idx], then returns the new level and how long it lasts.
    task automatic measure(input int idx, output logic val, output int len);
        logic v;
        int   n;
        v = led_o[idx];
        n = 0;
        while (led_o[idx] === v && n < 200) begin @(negedge pixel_clk); n++; end
        val = led_o[idx];
        len = 0;
        while (led_o[idx] === val && len < 200) begin @(negedge pixel_clk); len++; end
    endtask

    task automatic wait_level(input string tag, input int idx, input logic lvl);
        int n;
        n = 0;
        while (led_o[idx] !== lvl && n < 100) begin @(negedge pixel_clk); n++; end
        check(tag, 32'(led_o[idx]), 32'(lvl));
    endtask

    // ch0 runs BLINK with period 0, so each change of led_o[0] marks a tick edge.
    task automatic sync_tick(input string tag);
        logic v;
        int   n;
        v = led_o[0];
        n = 0;
        while (led_o[0] === v && n < 20) begin @(negedge pixel_clk); n++; end
        check(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic count_high(input int idx, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge pixel_clk);
            if (led_o[idx]) hi++;
        end
    endtask

    initial begin
        logic v;
        int   len;
        int   hi;

        sys_rst         = 1'b1;
        trig_i          = '0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_reg  = '0;
        cfg_if.cfg_data = '0;

        step(3);
        check("rst_hold_rst_o", 32'(rst_o), 32'd1);
        check("rst_hold_led", 32'(led_o), 32'd0);

        sys_rst         = 1'b0;
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = 2'd0;
        cfg_if.cfg_reg  = REG_MODE;
        cfg_if.cfg_data = 8'd1;
        step(1);
        cfg_if.cfg_we = 1'b0;
        check("rst_o_after_edge1", 32'(rst_o), 32'd1);
        step(1);
        check("rst_o_after_edge2", 32'(rst_o), 32'd0);
        step(3);
        check("cfg_in_rst_ignored", 32'(led_o), 32'd0);

        cfg_write(0, REG_MODE, 2);
        cfg_write(0, REG_PERIOD, 3);
        measure(0, v, len);
        check("blink_p3_half_a", 32'(len), 32'd12);
        measure(0, v, len);
        check("blink_p3_half_b", 32'(len), 32'd12);

        wait_level("blink_reach_high", 0, 1'b1);
        cfg_write(0, REG_PERIOD, 0);
        check("period_write_clears_led", 32'(led_o[0]), 32'd0);
        measure(0, v, len);
        check("blink_p0_half_a", 32'(len), 32'd4);
        measure(0, v, len);
        check("blink_p0_half_b", 32'(len), 32'd4);

        cfg_write(1, REG_MODE, 3);
        cfg_write(1, REG_PERIOD, 4);
        cfg_write(1, REG_DUTY, 1);
        measure(1, v, len);
        check("pwm_d1_seg_a", 32'(len), v ? 32'd4 : 32'd12);
        measure(1, v, len);
        check("pwm_d1_seg_b", 32'(len), v ? 32'd4 : 32'd12);
        cfg_write(1, REG_DUTY, 0);
        step(1);
        count_high(1, 20, hi);
        check("pwm_d0_const_low", 32'(hi), 32'd0);
        cfg_write(1, REG_DUTY, 5);
        step(1);
        count_high(1, 20, hi);
        check("pwm_d5_const_high", 32'(hi), 32'd20);

        cfg_write(2, REG_MODE, 4);
        cfg_write(2, REG_PERIOD, 2);
        sync_tick("sync_pulse1");
        trig_i[2] = 1'b1;
        step(1);
        trig_i[2] = 1'b0;
        check("pulse_rise", 32'(led_o[2]), 32'd1);
        step(6);
        check("pulse_high_before_2nd_tick", 32'(led_o[2]), 32'd1);
        step(1);
        check("pulse_low_after_2nd_tick", 32'(led_o[2]), 32'd0);

        sync_tick("sync_pulse2");
        trig_i[2] = 1'b1;
        step(1);
        trig_i[2] = 1'b0;
        step(4);
        trig_i[2] = 1'b1;
        step(1);
        trig_i[2] = 1'b0;
        step(2);
        check("retrig_extends", 32'(led_o[2]), 32'd1);
        step(3);
        check("retrig_high_end", 32'(led_o[2]), 32'd1);
        step(1);
        check("retrig_low", 32'(led_o[2]), 32'd0);

        sync_tick("sync_pulse3");
        trig_i[2] = 1'b1;
        step(1);
        trig_i[2] = 1'b0;
        step(6);
        trig_i[2] = 1'b1;
        step(1);
        trig_i[2] = 1'b0;
        check("trig_on_terminal_tick", 32'(led_o[2]), 32'd1);
        step(7);
        check("trig_terminal_high_end", 32'(led_o[2]), 32'd1);
        step(1);
        check("trig_terminal_low", 32'(led_o[2]), 32'd0);

        cfg_write(3, REG_MODE, 2);
        cfg_write(3, REG_PERIOD, 0);
        step(8);
        sync_tick("sync_mode_write");
        step(3);
        if (led_o[3]) step(4);
        cfg_write(3, REG_MODE, 2);
        check("mode_write_beats_tick", 32'(led_o[3]), 32'd0);

        cfg_write(1, REG_MODE, 1);
        step(1);
        check("mode_on", 32'(led_o[1]), 32'd1);
        cfg_write(1, 2'd3, 0);
        check("reg3_no_change_a", 32'(led_o[1]), 32'd1);
        step(3);
        check("reg3_no_change_b", 32'(led_o[1]), 32'd1);
        cfg_write(1, REG_MODE, 6);
        step(1);
        count_high(1, 8, hi);
        check("mode6_off", 32'(hi), 32'd0);

        wait_level("blink_high_before_rst", 0, 1'b1);
        sys_rst = 1'b1;
        #1;
        check("midrun_rst_led", 32'(led_o), 32'd0);
        check("midrun_rst_rst_o", 32'(rst_o), 32'd1);
        step(2);
        sys_rst = 1'b0;
        step(3);
        check("after_midrun_rst_o", 32'(rst_o), 32'd0);
        check("after_midrun_led", 32'(led_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
